// File: rtl/ysyx_lsu_pkg.sv
// Shared encodings for the load/store unit: decode select codes and FSM states.
package ysyx_lsu_pkg;

    // Load select encoding (shared with the decode unit)
    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LBU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LHU  = 3'b100;
    localparam logic [2:0] RD_LW   = 3'b101;

    // Store select encoding (shared with the decode unit)
    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_SB   = 2'b01;
    localparam logic [1:0] WR_SH   = 2'b10;
    localparam logic [1:0] WR_SW   = 2'b11;

    // LSU transaction states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/ysyx_lsu_lane.sv
// Byte-lane logic for the LSU: store lane steering, load extraction/extension
// and the misalignment check on an incoming request. Purely combinational.
module ysyx_lsu_lane
    import ysyx_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  rd_sel,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    input  logic [1:0]  chk_addr_lo,
    input  logic [2:0]  chk_rd_sel,
    input  logic [1:0]  chk_wr_sel,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        is_half_s;
    logic        is_word_s;

    // Store path: replicate data across lanes and enable only the addressed bytes
    always_comb begin
        wmask      = 4'b0000;
        wdata_lane = 32'h0000_0000;
        case (wr_sel)
            WR_SB: begin
                wmask      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            WR_SH: begin
                wmask      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            WR_SW: begin
                wmask      = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                wmask      = 4'b0000;
                wdata_lane = 32'h0000_0000;
            end
        endcase
    end

    // Load path: pick the addressed byte/halfword and extend it
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        rdata_ext = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = raw_word[7:0];
            2'd1:    byte_s = raw_word[15:8];
            2'd2:    byte_s = raw_word[23:16];
            2'd3:    byte_s = raw_word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = raw_word[31:16];
        end else begin
            half_s = raw_word[15:0];
        end
        case (rd_sel)
            RD_LB:   rdata_ext = {{24{byte_s[7]}}, byte_s};
            RD_LBU:  rdata_ext = {24'h00_0000, byte_s};
            RD_LH:   rdata_ext = {{16{half_s[15]}}, half_s};
            RD_LHU:  rdata_ext = {16'h0000, half_s};
            RD_LW:   rdata_ext = raw_word;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

    // Misalignment: halfwords need even addresses, words need 4-byte alignment
    always_comb begin
        is_half_s = (chk_rd_sel == RD_LH) || (chk_rd_sel == RD_LHU) || (chk_wr_sel == WR_SH);
        is_word_s = (chk_rd_sel == RD_LW) || (chk_wr_sel == WR_SW);
        misalign  = (is_half_s && chk_addr_lo[0]) || (is_word_s && (chk_addr_lo != 2'b00));
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Multi-cycle load/store unit: accepts one request from execute, runs it over
// a valid/ready memory port and returns a one-cycle write-back response.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_rd_sel,
    input  logic [1:0]        req_wr_sel,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_r;
    lsu_state_e        state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [2:0]        rd_sel_r;
    logic [1:0]        wr_sel_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_r;

    logic              accept_s;
    logic              illegal_s;
    logic              misalign_s;
    logic              err_s;
    logic              noop_s;
    logic              req_phase_s;
    logic              resp_phase_s;
    logic [3:0]        wmask_s;
    logic [DATA_W-1:0] wdata_lane_s;
    logic [DATA_W-1:0] ld_data_s;

    // Store/load lanes work on the latched request; the misalign check looks
    // at the incoming request so the error can be latched at accept time.
    ysyx_lsu_lane u_lane (
        .addr_lo     (addr_r[1:0]),
        .rd_sel      (rd_sel_r),
        .wr_sel      (wr_sel_r),
        .wdata       (wdata_r),
        .raw_word    (mem_rdata),
        .chk_addr_lo (req_addr[1:0]),
        .chk_rd_sel  (req_rd_sel),
        .chk_wr_sel  (req_wr_sel),
        .wmask       (wmask_s),
        .wdata_lane  (wdata_lane_s),
        .rdata_ext   (ld_data_s),
        .misalign    (misalign_s)
    );

    assign accept_s     = (state_r == S_IDLE) && req_valid;
    assign illegal_s    = ((req_rd_sel != RD_NONE) && (req_wr_sel != WR_NONE)) ||
                          (req_rd_sel == 3'b110) || (req_rd_sel == 3'b111);
    assign err_s        = illegal_s || misalign_s;
    assign noop_s       = (req_rd_sel == RD_NONE) && (req_wr_sel == WR_NONE);
    assign req_phase_s  = (state_r == S_REQ);
    assign resp_phase_s = (state_r == S_RESP);

    // State register; async reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: errors and no-ops skip the memory port entirely
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    if (err_s || noop_s) begin
                        state_nxt_s = S_RESP;
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RESP:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Request latch and extended load result; result clears on each accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            rd_sel_r <= 3'b000;
            wr_sel_r <= 2'b00;
            err_r    <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            rd_sel_r <= req_rd_sel;
            wr_sel_r <= req_wr_sel;
            err_r    <= err_s;
            rdata_r  <= {DATA_W{1'b0}};
        end else if ((state_r == S_WAIT) && mem_resp_valid) begin
            rdata_r  <= ld_data_s;
        end
    end

    // Outputs come only from latched registers gated by state decode
    assign req_ready     = (state_r == S_IDLE);
    assign mem_req_valid = req_phase_s;
    assign mem_addr      = req_phase_s ? {addr_r[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
    assign mem_wen       = req_phase_s && (wr_sel_r != WR_NONE);
    assign mem_wdata     = req_phase_s ? wdata_lane_s : {DATA_W{1'b0}};
    assign mem_wmask     = req_phase_s ? wmask_s : 4'b0000;
    assign resp_valid    = resp_phase_s;
    assign resp_err      = resp_phase_s && err_r;
    assign resp_rdata    = resp_phase_s ? rdata_r : {DATA_W{1'b0}};

endmodule
